// File: rtl/line_memory_bank.sv
// line_memory_bank
//   Line-organised data memory mapped at BASE_ADDRESS. Each of DEPTH lines holds
//   WORDS_PER_LINE words of WORD_W bits. One word-granular request per cycle is
//   accepted over a valid/ready handshake, with a single registered response slot.
//   Writes merge enabled bytes into the stored word. Misaligned, below-base and
//   past-the-end accesses complete with resp_err=1 and leave the array untouched.
//
//   Optional feature macro: LINE_MEM_CLEAR_EN
//     defined   : after rst the array is zeroed one line per cycle; req_rdy stays 0
//                 until the last line has been cleared.
//     undefined : no clear sequencer; array contents are undefined after power-up.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_v / req_rdy          request handshake
//   req_we                   1 = write, 0 = read
//   req_adr                  byte address (ADDR_W)
//   req_data, req_strobe     write data and per-byte enables
//   resp_v / resp_rdy        response handshake
//   resp_data                read data (0 for writes and errors)
//   resp_err                 access error flag
//
// States (LINE_MEM_CLEAR_EN only)
//   state    | meaning
//   ST_CLEAR | zeroing line clr_cnt_q this cycle; requests refused
//   ST_RUN   | normal request service

module line_memory_bank #(
   parameter int unsigned ADDR_W         = 32,
   parameter logic [31:0] BASE_ADDRESS   = 32'h0000_4E20,
   parameter int unsigned DEPTH          = 1024,
   parameter int unsigned WORD_W         = 32,
   parameter int unsigned WORDS_PER_LINE = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_v,
   output logic                  req_rdy,
   input  logic                  req_we,
   input  logic [ADDR_W-1:0]     req_adr,
   input  logic [WORD_W-1:0]     req_data,
   input  logic [WORD_W/8-1:0]   req_strobe,
   output logic                  resp_v,
   input  logic                  resp_rdy,
   output logic [WORD_W-1:0]     resp_data,
   output logic                  resp_err
);

   localparam int unsigned NBYTES   = WORD_W / 8;
   localparam int unsigned BYTE_OFF = $clog2(NBYTES);
   localparam int unsigned WORD_OFF = $clog2(WORDS_PER_LINE);
   localparam int unsigned IDX_W    = $clog2(DEPTH);
   // word select keeps at least one bit so a single-word line still elaborates
   localparam int unsigned WSEL_W   = (WORD_OFF > 0) ? WORD_OFF : 1;
   localparam int unsigned LINE_W   = WORDS_PER_LINE * WORD_W;

   localparam logic [ADDR_W-1:0] BASE_A     = ADDR_W'(BASE_ADDRESS);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(NBYTES - 1);
   localparam logic [ADDR_W-1:0] WSEL_MASK  = ADDR_W'(WORDS_PER_LINE - 1);
   // one extra bit so a memory spanning the whole address space still compares correctly
   localparam logic [ADDR_W:0]   MEM_BYTES  = (ADDR_W+1)'(DEPTH * WORDS_PER_LINE * NBYTES);

   logic [LINE_W-1:0] mem [DEPTH];

   logic [ADDR_W-1:0] local_adr;
   logic              req_err;
   logic [IDX_W-1:0]  line_idx;
   logic [WSEL_W-1:0] word_sel;
   logic [LINE_W-1:0] cur_line;
   logic [WORD_W-1:0] cur_word;
   logic [WORD_W-1:0] merged_word;
   logic [LINE_W-1:0] merged_line;
   logic              run;
   logic              accept;
   logic              wr_en;
   logic              rd_en;

   logic              resp_v_q,    resp_v_d;
   logic              resp_err_q,  resp_err_d;
   logic [WORD_W-1:0] resp_data_q, resp_data_d;

   assign local_adr = req_adr - BASE_A;
   assign req_err   = ((local_adr & ALIGN_MASK) != '0)
                    | (req_adr < BASE_A)
                    | ({1'b0, local_adr} >= MEM_BYTES);
   assign line_idx  = IDX_W'(local_adr >> (BYTE_OFF + WORD_OFF));
   assign word_sel  = WSEL_W'((local_adr >> BYTE_OFF) & WSEL_MASK);
   assign cur_line  = mem[line_idx];

   always_comb begin
      cur_word    = cur_line[word_sel*WORD_W +: WORD_W];
      merged_word = cur_word;
      for (int b = 0; b < NBYTES; b++) begin
         if (req_strobe[b]) merged_word[8*b +: 8] = req_data[8*b +: 8];
      end
      merged_line = cur_line;
      merged_line[word_sel*WORD_W +: WORD_W] = merged_word;
   end

`ifdef LINE_MEM_CLEAR_EN
   typedef enum logic {ST_CLEAR, ST_RUN} state_e;

   state_e           state_q, state_d;
   logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;
   logic             clr_en;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_CLEAR;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      clr_en    = 1'b0;
      case (state_q)
         ST_CLEAR: begin
            clr_en    = 1'b1;
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == IDX_W'(DEPTH - 1)) state_d = ST_RUN;
         end
         ST_RUN: ;
         default: state_d = ST_CLEAR;
      endcase
   end

   assign run = (state_q == ST_RUN);
`else
   assign run = 1'b1;
`endif

   assign req_rdy = run & (~resp_v_q | resp_rdy);
   assign accept  = req_v & req_rdy;
   // a request presented while rst is high must not disturb the array
   assign wr_en   = accept & req_we & ~req_err & ~rst;
   assign rd_en   = accept & ~req_we & ~req_err;

   always_ff @(posedge clk) begin
      if (wr_en) mem[line_idx] <= merged_line;
`ifdef LINE_MEM_CLEAR_EN
      if (clr_en) mem[clr_cnt_q] <= '0;
`endif
   end

   always_comb begin
      resp_v_d    = resp_v_q;
      resp_err_d  = resp_err_q;
      resp_data_d = resp_data_q;
      if (accept) begin
         resp_v_d    = 1'b1;
         resp_err_d  = req_err;
         resp_data_d = rd_en ? cur_word : '0;
      end else if (resp_v_q && resp_rdy) begin
         resp_v_d    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         resp_v_q    <= 1'b0;
         resp_err_q  <= 1'b0;
         resp_data_q <= '0;
      end else begin
         resp_v_q    <= resp_v_d;
         resp_err_q  <= resp_err_d;
         resp_data_q <= resp_data_d;
      end
   end

   assign resp_v    = resp_v_q;
   assign resp_err  = resp_err_q;
   assign resp_data = resp_data_q;

endmodule

// File: tb/tb_line_memory_bank.sv
module tb_line_memory_bank;

   localparam logic [31:0] BASE      = 32'h0000_4E20;
   localparam logic [31:0] MEM_BYTES = 32'd16384;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_v;
   logic        req_rdy;
   logic        req_we;
   logic [31:0] req_adr;
   logic [31:0] req_data;
   logic [3:0]  req_strobe;
   logic        resp_v;
   logic        resp_rdy;
   logic [31:0] resp_data;
   logic        resp_err;

   line_memory_bank dut (
      .clk        (clk),
      .rst        (rst),
      .req_v      (req_v),
      .req_rdy    (req_rdy),
      .req_we     (req_we),
      .req_adr    (req_adr),
      .req_data   (req_data),
      .req_strobe (req_strobe),
      .resp_v     (resp_v),
      .resp_rdy   (resp_rdy),
      .resp_data  (resp_data),
      .resp_err   (resp_err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // reference model: word-indexed contents plus a mask of bytes whose value is known
   logic [31:0] mm [int];
   logic [31:0] km [int];
   bit          clr_known = 1'b0;
   logic        m_v    = 1'b0;
   logic        m_err  = 1'b0;
   logic [31:0] m_data = '0;
   logic [31:0] m_mask = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // one clock cycle: drive inputs at a falling edge, predict, then check after the rising edge
   task automatic cyc(input bit v, input bit we, input logic [31:0] adr,
                      input logic [31:0] d, input logic [3:0] s, input bit rr);
      bit          acc;
      bit          err;
      logic [31:0] loc;
      logic [31:0] w;
      logic [31:0] k;
      int          f;
      req_v = v; req_we = we; req_adr = adr; req_data = d; req_strobe = s; resp_rdy = rr;
      #1;
      check("req_rdy", req_rdy, (!m_v || rr));
      acc = v && (!m_v || rr);
      if (acc) begin
         loc = adr - BASE;
         err = (adr < BASE) || (loc % 4 != 0) || (loc >= MEM_BYTES);
         f   = int'(loc / 4);
         m_v = 1'b1; m_err = err; m_data = '0; m_mask = '1;
         if (!err) begin
            if (mm.exists(f)) begin w = mm[f]; k = km[f]; end
            else begin w = '0; k = clr_known ? '1 : '0; end
            if (we) begin
               for (int b = 0; b < 4; b++) begin
                  if (s[b]) begin w[8*b +: 8] = d[8*b +: 8]; k[8*b +: 8] = 8'hFF; end
               end
               mm[f] = w; km[f] = k;
            end else begin
               m_mask = k;
               m_data = w & k;
            end
         end
      end else if (m_v && rr) begin
         m_v = 1'b0;
      end
      @(negedge clk);
      check("resp_v", resp_v, m_v);
      if (m_v) begin
         check("resp_data", resp_data & m_mask, m_data);
         check("resp_err", resp_err, m_err);
      end
   endtask

   task automatic post_reset();
`ifdef LINE_MEM_CLEAR_EN
      int cnt = 0;
      #1;
      while (req_rdy === 1'b0 && cnt < 2000) begin
         cnt++;
         @(negedge clk);
         #1;
      end
      check("clear_cycles", cnt, 1024);
      clr_known = 1'b1;
      mm.delete();
      km.delete();
`else
      #1;
      check("rdy_after_reset", req_rdy, 1'b1);
`endif
   endtask

   task automatic do_reset();
      rst = 1'b1; req_v = 1'b0; resp_rdy = 1'b0;
      @(negedge clk);
      check("rst_resp_v", resp_v, 1'b0);
      check("rst_resp_data", resp_data, 32'h0);
      check("rst_resp_err", resp_err, 1'b0);
      m_v = 1'b0;
      rst = 1'b0;
      post_reset();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] adr;
      int          r;
      rst = 1'b1; req_v = 1'b0; req_we = 1'b0; req_adr = '0;
      req_data = '0; req_strobe = '0; resp_rdy = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      post_reset();

`ifdef LINE_MEM_CLEAR_EN
      cyc(1, 0, 32'h4E20, 0, 0, 1); check("clr_4E20", resp_data, 32'h0);
      cyc(1, 0, 32'h5234, 0, 0, 1); check("clr_5234", resp_data, 32'h0);
      cyc(1, 0, 32'h8E1C, 0, 0, 1); check("clr_8E1C", resp_data, 32'h0);
`endif

      // full-word write then read back
      cyc(1, 1, 32'h4E20, 32'h1234_5678, 4'hF, 1);
      cyc(1, 1, 32'h4E24, 32'hDEAD_BEEF, 4'hF, 1);
      check("wr_data_zero", resp_data, 32'h0);
      cyc(1, 0, 32'h4E24, 0, 0, 1);
      check("rd_4E24", resp_data, 32'hDEAD_BEEF);
      cyc(0, 0, 0, 0, 0, 1);

      // single-byte strobe merge
      cyc(1, 1, 32'h4E24, 32'h0000_1200, 4'b0010, 1);
      cyc(1, 0, 32'h4E24, 0, 0, 1);
      check("merge_4E24", resp_data, 32'hDEAD_12EF);
      cyc(1, 0, 32'h4E20, 0, 0, 1);
      check("keep_4E20", resp_data, 32'h1234_5678);

      // error accesses leave the array alone
      cyc(1, 1, 32'h4E22, 32'hFFFF_FFFF, 4'hF, 1);
      check("err_misaligned", resp_err, 1'b1);
      cyc(1, 1, 32'h4E1C, 32'hFFFF_FFFF, 4'hF, 1);
      check("err_below", resp_err, 1'b1);
      cyc(1, 1, 32'h8E20, 32'hFFFF_FFFF, 4'hF, 1);
      check("err_past_end", resp_err, 1'b1);
      check("err_data", resp_data, 32'h0);
      cyc(1, 0, 32'h4E20, 0, 0, 1);
      check("after_err_4E20", resp_data, 32'h1234_5678);
      check("after_err_ok", resp_err, 1'b0);

      // back-pressure: response holds, stalled request is refused
      cyc(1, 0, 32'h4E24, 0, 0, 1);
      for (int i = 0; i < 3; i++) begin
         cyc(1, 1, 32'h4E24, 32'hFFFF_FFFF, 4'hF, 0);
         check("stall_hold", resp_data, 32'hDEAD_12EF);
      end
      cyc(1, 0, 32'h4E20, 0, 0, 1);
      cyc(1, 0, 32'h4E24, 0, 0, 1);
      check("b2b_4E24", resp_data, 32'hDEAD_12EF);
      cyc(1, 0, 32'h4E20, 0, 0, 1);
      cyc(1, 0, 32'h4E24, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 1);

      // reset with a pending response
      cyc(1, 0, 32'h4E24, 0, 0, 0);
      do_reset();

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 19);
         if (r < 15)       adr = BASE + 4 * $urandom_range(0, 31);
         else if (r == 15) adr = BASE + 4 * $urandom_range(0, 31) + $urandom_range(1, 3);
         else if (r == 16) adr = BASE - 4 * $urandom_range(1, 4);
         else if (r == 17) adr = BASE + MEM_BYTES + 4 * $urandom_range(0, 3);
         else if (r == 18) adr = BASE + MEM_BYTES - 4;
         else              adr = BASE + 16 * $urandom_range(0, 1023) + 4 * $urandom_range(0, 3);
         cyc(($urandom_range(0, 3) != 0), $urandom_range(0, 1), adr, $urandom,
             4'($urandom_range(0, 15)), ($urandom_range(0, 9) < 7));
      end
      cyc(0, 0, 0, 0, 0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
